// File: rtl/design_variables.sv
// Shared widths, symbol/pair types and collector state encoding for the
// Smith-Waterman result path.
package design_variables;

   localparam int LETTER_WIDTH  = 2;
   localparam int SCORE_WIDTH   = 10;
   localparam int MAX_ALIGN_LEN = 64;
   localparam int LEN_WIDTH     = $clog2(MAX_ALIGN_LEN + 1);

   typedef struct packed {
      logic                    gap;
      logic [LETTER_WIDTH-1:0] base;
   } aln_sym_t;

   typedef struct packed {
      aln_sym_t query;
      aln_sym_t database;
   } aln_pair_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } col_state_t;

endpackage

// File: rtl/sw_result_collector_if.sv
// Aligner-stream and host-readout signals of the result collector.
// master = aligner/host side, slave = collector.
interface sw_result_collector_if #(
   parameter int LETTER_WIDTH = design_variables::LETTER_WIDTH,
   parameter int SCORE_WIDTH  = design_variables::SCORE_WIDTH,
   parameter int LEN_WIDTH    = design_variables::LEN_WIDTH
);
   logic                   output_valid;
   logic [LETTER_WIDTH:0]  query_seq_out;
   logic [LETTER_WIDTH:0]  database_seq_out;
   logic [SCORE_WIDTH-1:0] score;
   logic                   rd_req;
   logic                   res_avail;
   logic [SCORE_WIDTH-1:0] res_score;
   logic [LEN_WIDTH-1:0]   res_len;
   logic                   rd_valid;
   logic [LETTER_WIDTH:0]  rd_query;
   logic [LETTER_WIDTH:0]  rd_database;
   logic                   busy;
   logic                   data_lost;

   modport master (
      output output_valid, query_seq_out, database_seq_out, score, rd_req,
      input  res_avail, res_score, res_len, rd_valid, rd_query, rd_database,
             busy, data_lost
   );

   modport slave (
      input  output_valid, query_seq_out, database_seq_out, score, rd_req,
      output res_avail, res_score, res_len, rd_valid, rd_query, rd_database,
             busy, data_lost
   );
endinterface

// File: rtl/sw_lifo_mem.sv
// Pair storage for the collector: synchronous write, registered read, no reset
// so it maps onto block RAM.
module sw_lifo_mem #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 6,
   parameter int AW    = 6
) (
   input  logic             clk,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [WIDTH-1:0] o_rd_data
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;
endmodule

// File: rtl/sw_result_collector.sv
// Captures the traceback pair stream and replays it last-in-first-out, so the
// host sees the alignment start-to-end.
module sw_result_collector #(
   parameter int LETTER_WIDTH = design_variables::LETTER_WIDTH,
   parameter int SCORE_WIDTH  = design_variables::SCORE_WIDTH,
   parameter int MAX_LEN      = design_variables::MAX_ALIGN_LEN,
   parameter int LEN_WIDTH    = $clog2(MAX_LEN + 1)
) (
   input logic                  clk,
   input logic                  rst_n,
   sw_result_collector_if.slave bus
);
   import design_variables::*;

   localparam int SYM_W  = LETTER_WIDTH + 1;
   localparam int PAIR_W = 2 * SYM_W;
   localparam int AW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [LEN_WIDTH-1:0] FULL_PTR = LEN_WIDTH'(MAX_LEN);

   col_state_t             r_state, w_state_next;
   logic [LEN_WIDTH-1:0]   r_ptr;
   logic [LEN_WIDTH-1:0]   r_res_len;
   logic [SCORE_WIDTH-1:0] r_res_score;
   logic                   r_res_avail;
   logic                   r_rd_valid;
   logic                   r_data_lost;
   logic                   r_has_read;

   logic                   w_wr_en, w_rd_en, w_drop, w_close, w_release;
   logic [AW-1:0]          w_wr_addr, w_rd_addr;
   logic [PAIR_W-1:0]      w_mem_q;

   always_comb begin
      w_state_next = r_state;
      w_wr_en      = 1'b0;
      w_wr_addr    = '0;
      w_rd_en      = 1'b0;
      w_rd_addr    = '0;
      w_drop       = 1'b0;
      w_close      = 1'b0;
      w_release    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.output_valid) begin
               w_wr_en      = 1'b1;
               w_state_next = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (bus.output_valid) begin
               if (r_ptr < FULL_PTR) begin
                  w_wr_en   = 1'b1;
                  w_wr_addr = AW'(r_ptr);
               end else begin
                  w_drop = 1'b1;
               end
            end else begin
               w_close      = 1'b1;
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_drop = bus.output_valid;
            // Leave DONE one cycle after the emptying pop, never on it.
            if (r_ptr == '0) begin
               w_release    = 1'b1;
               w_state_next = ST_IDLE;
            end else if (bus.rd_req) begin
               w_rd_en   = 1'b1;
               w_rd_addr = AW'(r_ptr - 1'b1);
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_res_len   <= '0;
         r_res_score <= '0;
         r_res_avail <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_data_lost <= 1'b0;
         r_has_read  <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_rd_valid <= w_rd_en;
         if (w_wr_en) begin
            r_ptr       <= r_ptr + 1'b1;
            r_res_score <= bus.score;
         end else if (w_rd_en) begin
            r_ptr      <= r_ptr - 1'b1;
            r_has_read <= 1'b1;
         end
         if (r_state == ST_IDLE && bus.output_valid) r_data_lost <= 1'b0;
         else if (w_drop)                            r_data_lost <= 1'b1;
         if (w_close) begin
            r_res_len   <= r_ptr;
            r_res_avail <= 1'b1;
         end else if (w_release) begin
            r_res_avail <= 1'b0;
         end
      end
   end

   sw_lifo_mem #(
      .DEPTH (MAX_LEN),
      .WIDTH (PAIR_W),
      .AW    (AW)
   ) u_mem (
      .clk       (clk),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (w_wr_addr),
      .i_wr_data ({bus.query_seq_out, bus.database_seq_out}),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_mem_q)
   );

   // Stale RAM contents stay hidden until the first pop after reset.
   assign bus.rd_query    = r_has_read ? w_mem_q[PAIR_W-1:SYM_W] : '0;
   assign bus.rd_database = r_has_read ? w_mem_q[SYM_W-1:0]      : '0;
   assign bus.rd_valid    = r_rd_valid;
   assign bus.res_avail   = r_res_avail;
   assign bus.res_score   = r_res_score;
   assign bus.res_len     = r_res_len;
   assign bus.busy        = (r_state == ST_COLLECT);
   assign bus.data_lost   = r_data_lost;
endmodule

// File: tb/tb_sw_result_collector.sv
// Directed, table-driven bench for sw_result_collector: capture, LIFO replay,
// overflow, drops during DONE and asynchronous reset mid-stream.
module tb_sw_result_collector;
   import design_variables::*;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   sw_result_collector_if bus();

   sw_result_collector dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic       ov;
      logic [2:0] q;
      logic [2:0] d;
      logic [9:0] sc;
      logic       rdreq;
      logic       e_avail;
      logic [6:0] e_len;
      logic [9:0] e_score;
      logic       e_rdv;
      logic [2:0] e_rq;
      logic [2:0] e_rd;
      logic       e_busy;
      logic       e_lost;
   } vec_t;

   vec_t vecs[11];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic avail, input logic [6:0] len,
                            input logic [9:0] sc, input logic rdv, input logic [2:0] rq,
                            input logic [2:0] rd, input logic busy, input logic lost);
      check({tag, ".res_avail"},   bus.res_avail,   avail);
      check({tag, ".res_len"},     bus.res_len,     len);
      check({tag, ".res_score"},   bus.res_score,   sc);
      check({tag, ".rd_valid"},    bus.rd_valid,    rdv);
      check({tag, ".rd_query"},    bus.rd_query,    rq);
      check({tag, ".rd_database"}, bus.rd_database, rd);
      check({tag, ".busy"},        bus.busy,        busy);
      check({tag, ".data_lost"},   bus.data_lost,   lost);
      $display("%s: avail=%0b len=%0d score=%0d rdv=%0b q=%0h d=%0h busy=%0b lost=%0b",
               tag, bus.res_avail, bus.res_len, bus.res_score, bus.rd_valid,
               bus.rd_query, bus.rd_database, bus.busy, bus.data_lost);
   endtask

   task automatic beat(input logic [2:0] q, input logic [2:0] d, input logic [9:0] sc);
      bus.output_valid     = 1'b1;
      bus.query_seq_out    = q;
      bus.database_seq_out = d;
      bus.score            = sc;
      tick();
      bus.output_valid     = 1'b0;
   endtask

   initial begin
      rst_n                = 1'b0;
      bus.output_valid     = 1'b0;
      bus.query_seq_out    = '0;
      bus.database_seq_out = '0;
      bus.score            = '0;
      bus.rd_req           = 1'b0;

      // A,C,G,T queries, db symbols with gap set; popped back as T,G,C,A
      vecs[0]  = '{1'b1, 3'd0, 3'd4, 10'd5, 1'b0, 1'b0, 7'd0, 10'd5, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 3'd1, 3'd5, 10'd6, 1'b0, 1'b0, 7'd0, 10'd6, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 3'd2, 3'd6, 10'd7, 1'b0, 1'b0, 7'd0, 10'd7, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 3'd3, 3'd7, 10'd9, 1'b0, 1'b0, 7'd0, 10'd9, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 3'd0, 3'd0, 10'd0, 1'b0, 1'b1, 7'd4, 10'd9, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 3'd0, 3'd0, 10'd0, 1'b1, 1'b1, 7'd4, 10'd9, 1'b1, 3'd3, 3'd7, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 3'd0, 3'd0, 10'd0, 1'b1, 1'b1, 7'd4, 10'd9, 1'b1, 3'd2, 3'd6, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 3'd0, 3'd0, 10'd0, 1'b1, 1'b1, 7'd4, 10'd9, 1'b1, 3'd1, 3'd5, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 3'd0, 3'd0, 10'd0, 1'b1, 1'b1, 7'd4, 10'd9, 1'b1, 3'd0, 3'd4, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 3'd0, 3'd0, 10'd0, 1'b1, 1'b0, 7'd4, 10'd9, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 3'd0, 3'd0, 10'd0, 1'b1, 1'b0, 7'd4, 10'd9, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0};

      tick();
      tick();
      check_all("reset", 1'b0, 7'd0, 10'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
      rst_n = 1'b1;

      // Four-beat capture and continuous-request readout
      for (int i = 0; i < 11; i++) begin
         bus.output_valid     = vecs[i].ov;
         bus.query_seq_out    = vecs[i].q;
         bus.database_seq_out = vecs[i].d;
         bus.score            = vecs[i].sc;
         bus.rd_req           = vecs[i].rdreq;
         tick();
         check_all($sformatf("vec%0d", i), vecs[i].e_avail, vecs[i].e_len, vecs[i].e_score,
                   vecs[i].e_rdv, vecs[i].e_rq, vecs[i].e_rd, vecs[i].e_busy, vecs[i].e_lost);
      end
      bus.output_valid = 1'b0;
      bus.rd_req       = 1'b0;

      // Single-beat stream with maximum score
      beat(3'b101, 3'b010, 10'h3FF);
      tick();
      check_all("single.done", 1'b1, 7'd1, 10'h3FF, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0);
      bus.rd_req = 1'b1;
      tick();
      bus.rd_req = 1'b0;
      check_all("single.pop", 1'b1, 7'd1, 10'h3FF, 1'b1, 3'b101, 3'b010, 1'b0, 1'b0);
      tick();
      check_all("single.idle", 1'b0, 7'd1, 10'h3FF, 1'b0, 3'b101, 3'b010, 1'b0, 1'b0);
      bus.rd_req = 1'b1;
      tick();
      bus.rd_req = 1'b0;
      check("single.late_req.rd_valid", bus.rd_valid, 1'b0);

      // Overflow: 67 beats, pair encodes beat number mod 64, score = beat number
      for (int k = 1; k <= 67; k++) begin
         logic [6:0] kk;
         kk = 7'(k);
         beat(kk[5:3], kk[2:0], 10'(k));
         if (k == 64) check("ovf.beat64.data_lost", bus.data_lost, 1'b0);
         if (k == 65) check("ovf.beat65.data_lost", bus.data_lost, 1'b1);
      end
      tick();
      check_all("ovf.done", 1'b1, 7'd64, 10'd64, 1'b0, 3'b101, 3'b010, 1'b0, 1'b1);
      bus.rd_req = 1'b1;
      for (int j = 0; j < 64; j++) begin
         logic [6:0] kk;
         kk = 7'(64 - j);
         tick();
         check($sformatf("ovf.pop%0d.rd_valid", j), bus.rd_valid, 1'b1);
         check($sformatf("ovf.pop%0d.pair", j), {bus.rd_query, bus.rd_database}, {kk[5:3], kk[2:0]});
         $display("ovf.pop%0d: q=%0h d=%0h", j, bus.rd_query, bus.rd_database);
      end
      bus.rd_req = 1'b0;
      tick();
      check_all("ovf.idle", 1'b0, 7'd64, 10'd64, 1'b0, 3'b000, 3'b001, 1'b0, 1'b1);

      // Beat during DONE is dropped; stored result survives
      beat(3'd0, 3'd4, 10'd5);
      check("drop.first_beat.data_lost", bus.data_lost, 1'b0);
      beat(3'd1, 3'd5, 10'd6);
      beat(3'd2, 3'd6, 10'd7);
      beat(3'd3, 3'd7, 10'd9);
      tick();
      beat(3'd7, 3'd7, 10'd1);
      check_all("drop.pulse", 1'b1, 7'd4, 10'd9, 1'b0, 3'b000, 3'b001, 1'b0, 1'b1);
      bus.rd_req = 1'b1;
      for (int j = 0; j < 4; j++) begin
         logic [2:0] eq;
         eq = 3'(3 - j);
         tick();
         check_all($sformatf("drop.pop%0d", j), 1'b1, 7'd4, 10'd9, 1'b1, eq, 3'(4 + 3 - j), 1'b0, 1'b1);
      end
      bus.rd_req = 1'b0;
      tick();
      check("drop.after.res_avail", bus.res_avail, 1'b0);

      // Asynchronous reset in the middle of collection
      beat(3'd1, 3'd2, 10'd30);
      beat(3'd2, 3'd3, 10'd31);
      check("rst.pre.busy", bus.busy, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      check_all("rst.async", 1'b0, 7'd0, 10'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) beat({1'b0, 2'(i)}, {1'b1, 2'(i)}, 10'(20 + i));
      tick();
      check_all("rst.restream", 1'b1, 7'd3, 10'd22, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
      bus.rd_req = 1'b1;
      tick();
      bus.rd_req = 1'b0;
      check_all("rst.pop0", 1'b1, 7'd3, 10'd22, 1'b1, 3'b010, 3'b110, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
